// File: rtl/envm_fault_store.sv
// envm_fault_store: embedded-NVM model for the systolic-array self-test / self-recovery path.
//
// Holds per-test-type scan patterns (weight, activation, expected answer) behind a write port
// and a registered one-cycle read port. Records row / column / single-PE fault detections into
// a fault map, exposes the flattened map plus registered fault counts, and streams the PE map
// row by row over a valid/ready dump port.
//
// Build option: define ENVM_STICKY_ACCUM_EN to OR new detections into the stored map (faults
// accumulate across test passes); left undefined, each record overwrites the addressed entry.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pat_wr_*                        pattern write strobe / bank / entry / data
//   pat_rd_en, test_type,
//   test_counter                    pattern read request / bank / entry
//   Scan_data_*, pat_rd_err         registered read data, out-of-range flag of last read
//   detection_en, counter,
//   single_pe_detection,
//   row_fault_detection,
//   column_fault_detection          fault record strobe, index and detection data
//   fault_clear                     zero all maps (wins over detection_en)
//   envm_faulty_patterns_flat       PE map, row i at [i*COLS +: COLS]
//   faulty_row_map, faulty_column_map, faulty_*_count
//   dump_*                          row-by-row valid/ready stream of the PE map
module envm_fault_store #(
  parameter int unsigned ROWS              = 8,
  parameter int unsigned COLS              = 8,
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned ACTIVATION_WIDTH  = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(ROWS),
  parameter int unsigned NUM_TEST_TYPES    = 2,
  parameter int unsigned PATTERN_DEPTH     = 18,
  parameter int unsigned TYPE_WIDTH        = (NUM_TEST_TYPES > 1) ? $clog2(NUM_TEST_TYPES) : 1,
  parameter int unsigned PAT_ADDR_WIDTH    = $clog2(PATTERN_DEPTH),
  parameter int unsigned MAX_DIM           = (ROWS > COLS) ? ROWS : COLS,
  parameter int unsigned IDX_WIDTH         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  parameter int unsigned PE_CNT_WIDTH      = $clog2(ROWS * COLS + 1),
  parameter int unsigned ROW_CNT_WIDTH     = $clog2(ROWS + 1),
  parameter int unsigned COL_CNT_WIDTH     = $clog2(COLS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pat_wr_en,
  input  logic [TYPE_WIDTH-1:0]        pat_wr_type,
  input  logic [PAT_ADDR_WIDTH-1:0]    pat_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]      pat_wr_weight,
  input  logic [ACTIVATION_WIDTH-1:0]  pat_wr_activation,
  input  logic [PARTIAL_SUM_WIDTH-1:0] pat_wr_answer,
  input  logic                         pat_rd_en,
  input  logic [TYPE_WIDTH-1:0]        test_type,
  input  logic [PAT_ADDR_WIDTH-1:0]    test_counter,
  output logic [WEIGHT_WIDTH-1:0]      Scan_data_weight,
  output logic [ACTIVATION_WIDTH-1:0]  Scan_data_activation,
  output logic [PARTIAL_SUM_WIDTH-1:0] Scan_data_answer,
  output logic                         pat_rd_err,
  input  logic                         detection_en,
  input  logic [IDX_WIDTH-1:0]         counter,
  input  logic [COLS-1:0]              single_pe_detection,
  input  logic                         row_fault_detection,
  input  logic                         column_fault_detection,
  input  logic                         fault_clear,
  output logic [ROWS*COLS-1:0]         envm_faulty_patterns_flat,
  output logic [ROWS-1:0]              faulty_row_map,
  output logic [COLS-1:0]              faulty_column_map,
  output logic [PE_CNT_WIDTH-1:0]      faulty_pe_count,
  output logic [ROW_CNT_WIDTH-1:0]     faulty_row_count,
  output logic [COL_CNT_WIDTH-1:0]     faulty_col_count,
  input  logic                         dump_start,
  input  logic                         dump_ready,
  output logic                         dump_valid,
  output logic                         dump_last,
  output logic                         dump_busy,
  output logic [IDX_WIDTH-1:0]         dump_row_idx,
  output logic [COLS-1:0]              dump_data
);

  // One extra bit so the bound itself is representable for range compares.
  localparam logic [TYPE_WIDTH:0]     NumTypesW = (TYPE_WIDTH + 1)'(NUM_TEST_TYPES);
  localparam logic [PAT_ADDR_WIDTH:0] DepthW    = (PAT_ADDR_WIDTH + 1)'(PATTERN_DEPTH);
  localparam logic [IDX_WIDTH:0]      RowsW     = (IDX_WIDTH + 1)'(ROWS);
  localparam logic [IDX_WIDTH:0]      ColsW     = (IDX_WIDTH + 1)'(COLS);
  localparam logic [IDX_WIDTH-1:0]    LastRow   = IDX_WIDTH'(ROWS - 1);

  // Pattern banks: non-volatile, so deliberately outside the reset domain.
  logic [WEIGHT_WIDTH-1:0]      mem_weight [NUM_TEST_TYPES][PATTERN_DEPTH];
  logic [ACTIVATION_WIDTH-1:0]  mem_act    [NUM_TEST_TYPES][PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] mem_answer [NUM_TEST_TYPES][PATTERN_DEPTH];

  logic wr_ok, rd_ok;
  assign wr_ok = ({1'b0, pat_wr_type} < NumTypesW) && ({1'b0, pat_wr_addr} < DepthW);
  assign rd_ok = ({1'b0, test_type} < NumTypesW) && ({1'b0, test_counter} < DepthW);

  always_ff @(posedge clk) begin
    if (pat_wr_en && wr_ok) begin
      mem_weight[pat_wr_type][pat_wr_addr] <= pat_wr_weight;
      mem_act[pat_wr_type][pat_wr_addr]    <= pat_wr_activation;
      mem_answer[pat_wr_type][pat_wr_addr] <= pat_wr_answer;
    end
  end

  // Read-during-write to the same entry returns the old contents (NBA ordering).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Scan_data_weight     <= '0;
      Scan_data_activation <= '0;
      Scan_data_answer     <= '0;
      pat_rd_err           <= 1'b0;
    end else if (pat_rd_en) begin
      if (rd_ok) begin
        Scan_data_weight     <= mem_weight[test_type][test_counter];
        Scan_data_activation <= mem_act[test_type][test_counter];
        Scan_data_answer     <= mem_answer[test_type][test_counter];
        pat_rd_err           <= 1'b0;
      end else begin
        Scan_data_weight     <= '0;
        Scan_data_activation <= '0;
        Scan_data_answer     <= '0;
        pat_rd_err           <= 1'b1;
      end
    end
  end

  // Fault map.
  logic [COLS-1:0] pe_map_q [ROWS];
  logic [COLS-1:0] pe_map_d [ROWS];
  logic [ROWS-1:0] row_map_q, row_map_d;
  logic [COLS-1:0] col_map_q, col_map_d;

  always_comb begin
    pe_map_d  = pe_map_q;
    row_map_d = row_map_q;
    col_map_d = col_map_q;
    if (fault_clear) begin
      pe_map_d  = '{default: '0};
      row_map_d = '0;
      col_map_d = '0;
    end else if (detection_en) begin
      if ({1'b0, counter} < RowsW) begin
`ifdef ENVM_STICKY_ACCUM_EN
        pe_map_d[counter]  = pe_map_q[counter] | single_pe_detection;
        row_map_d[counter] = row_map_q[counter] | row_fault_detection;
`else
        pe_map_d[counter]  = single_pe_detection;
        row_map_d[counter] = row_fault_detection;
`endif
      end
      if ({1'b0, counter} < ColsW) begin
`ifdef ENVM_STICKY_ACCUM_EN
        col_map_d[counter] = col_map_q[counter] | column_fault_detection;
`else
        col_map_d[counter] = column_fault_detection;
`endif
      end
    end
  end

  // Popcounts are taken from the registered maps, hence one cycle behind them.
  logic [PE_CNT_WIDTH-1:0]  pe_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] row_cnt_d;
  logic [COL_CNT_WIDTH-1:0] col_cnt_d;

  always_comb begin
    pe_cnt_d  = '0;
    row_cnt_d = '0;
    col_cnt_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_cnt_d = row_cnt_d + ROW_CNT_WIDTH'(row_map_q[r]);
      for (int c = 0; c < COLS; c++) begin
        pe_cnt_d = pe_cnt_d + PE_CNT_WIDTH'(pe_map_q[r][c]);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      col_cnt_d = col_cnt_d + COL_CNT_WIDTH'(col_map_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pe_map_q         <= '{default: '0};
      row_map_q        <= '0;
      col_map_q        <= '0;
      faulty_pe_count  <= '0;
      faulty_row_count <= '0;
      faulty_col_count <= '0;
    end else begin
      pe_map_q         <= pe_map_d;
      row_map_q        <= row_map_d;
      col_map_q        <= col_map_d;
      faulty_pe_count  <= pe_cnt_d;
      faulty_row_count <= row_cnt_d;
      faulty_col_count <= col_cnt_d;
    end
  end

  always_comb begin
    envm_faulty_patterns_flat = '0;
    for (int r = 0; r < ROWS; r++) begin
      envm_faulty_patterns_flat[r*COLS +: COLS] = pe_map_q[r];
    end
  end

  assign faulty_row_map    = row_map_q;
  assign faulty_column_map = col_map_q;

  // Dump FSM.
  typedef enum logic [0:0] {StIdle, StSend} state_e;
  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        if (dump_ready) begin
          if (idx_q == LastRow) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Data is read live from the map so a detection to the pending row shows in its beat.
  always_comb begin
    dump_valid   = (state_q == StSend);
    dump_busy    = (state_q == StSend);
    dump_last    = (state_q == StSend) && (idx_q == LastRow);
    dump_row_idx = idx_q;
    dump_data    = pe_map_q[idx_q];
  end

endmodule

// File: tb/tb_envm_fault_store.sv
module tb_envm_fault_store;

  localparam int unsigned Rows = 8;
  localparam int unsigned Cols = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pat_wr_en;
  logic [0:0]  pat_wr_type;
  logic [4:0]  pat_wr_addr;
  logic [7:0]  pat_wr_weight;
  logic [7:0]  pat_wr_activation;
  logic [18:0] pat_wr_answer;
  logic        pat_rd_en;
  logic [0:0]  test_type;
  logic [4:0]  test_counter;
  logic [7:0]  Scan_data_weight;
  logic [7:0]  Scan_data_activation;
  logic [18:0] Scan_data_answer;
  logic        pat_rd_err;
  logic        detection_en;
  logic [2:0]  counter;
  logic [7:0]  single_pe_detection;
  logic        row_fault_detection;
  logic        column_fault_detection;
  logic        fault_clear;
  logic [63:0] envm_faulty_patterns_flat;
  logic [7:0]  faulty_row_map;
  logic [7:0]  faulty_column_map;
  logic [6:0]  faulty_pe_count;
  logic [3:0]  faulty_row_count;
  logic [3:0]  faulty_col_count;
  logic        dump_start;
  logic        dump_ready;
  logic        dump_valid;
  logic        dump_last;
  logic        dump_busy;
  logic [2:0]  dump_row_idx;
  logic [7:0]  dump_data;

  envm_fault_store dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .pat_wr_en                 (pat_wr_en),
    .pat_wr_type               (pat_wr_type),
    .pat_wr_addr               (pat_wr_addr),
    .pat_wr_weight             (pat_wr_weight),
    .pat_wr_activation         (pat_wr_activation),
    .pat_wr_answer             (pat_wr_answer),
    .pat_rd_en                 (pat_rd_en),
    .test_type                 (test_type),
    .test_counter              (test_counter),
    .Scan_data_weight          (Scan_data_weight),
    .Scan_data_activation      (Scan_data_activation),
    .Scan_data_answer          (Scan_data_answer),
    .pat_rd_err                (pat_rd_err),
    .detection_en              (detection_en),
    .counter                   (counter),
    .single_pe_detection       (single_pe_detection),
    .row_fault_detection       (row_fault_detection),
    .column_fault_detection    (column_fault_detection),
    .fault_clear               (fault_clear),
    .envm_faulty_patterns_flat (envm_faulty_patterns_flat),
    .faulty_row_map            (faulty_row_map),
    .faulty_column_map         (faulty_column_map),
    .faulty_pe_count           (faulty_pe_count),
    .faulty_row_count          (faulty_row_count),
    .faulty_col_count          (faulty_col_count),
    .dump_start                (dump_start),
    .dump_ready                (dump_ready),
    .dump_valid                (dump_valid),
    .dump_last                 (dump_last),
    .dump_busy                 (dump_busy),
    .dump_row_idx              (dump_row_idx),
    .dump_data                 (dump_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];
  logic [7:0]  exp_pe [Rows];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp_v;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    rst_n = 1'b0; pat_wr_en = 1'b0; pat_wr_type = '0; pat_wr_addr = '0;
    pat_wr_weight = '0; pat_wr_activation = '0; pat_wr_answer = '0;
    pat_rd_en = 1'b0; test_type = '0; test_counter = '0;
    detection_en = 1'b0; counter = '0; single_pe_detection = '0;
    row_fault_detection = 1'b0; column_fault_detection = 1'b0; fault_clear = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;

    // Reset state
    expect_val(64'h0); expect_val(64'h0); expect_val(64'h0); expect_val(64'h0);
    expect_val(64'h0); expect_val(64'h0);
    tick(); tick();
    chk("rst_weight", 64'(Scan_data_weight));
    chk("rst_rd_err", 64'(pat_rd_err));
    chk("rst_flat", envm_faulty_patterns_flat);
    chk("rst_pe_count", 64'(faulty_pe_count));
    chk("rst_dump_valid", 64'(dump_valid));
    chk("rst_dump_busy", 64'(dump_busy));
    rst_n = 1'b1;

    // Pattern writes
    pat_wr_en = 1'b1; pat_wr_type = 1'b0; pat_wr_addr = 5'd3;
    pat_wr_weight = 8'h5A; pat_wr_activation = 8'hC3; pat_wr_answer = 19'h01234;
    tick();
    pat_wr_type = 1'b1; pat_wr_addr = 5'd17;
    pat_wr_weight = 8'hFF; pat_wr_activation = 8'h80; pat_wr_answer = 19'h3FFFF;
    tick();
    pat_wr_en = 1'b0;

    // Reads: one-cycle latency
    pat_rd_en = 1'b1; test_type = 1'b0; test_counter = 5'd3;
    expect_val(64'h5A); expect_val(64'hC3); expect_val(64'h01234); expect_val(64'h0);
    tick();
    chk("rd_sa_weight", 64'(Scan_data_weight));
    chk("rd_sa_act", 64'(Scan_data_activation));
    chk("rd_sa_answer", 64'(Scan_data_answer));
    chk("rd_sa_err", 64'(pat_rd_err));
    test_type = 1'b1; test_counter = 5'd17;
    expect_val(64'hFF); expect_val(64'h80); expect_val(64'h3FFFF);
    tick();
    chk("rd_td_weight", 64'(Scan_data_weight));
    chk("rd_td_act", 64'(Scan_data_activation));
    chk("rd_td_answer", 64'(Scan_data_answer));
    test_type = 1'b0; test_counter = 5'd18;
    expect_val(64'h0); expect_val(64'h0); expect_val(64'h0); expect_val(64'h1);
    tick();
    chk("rd_oor_weight", 64'(Scan_data_weight));
    chk("rd_oor_act", 64'(Scan_data_activation));
    chk("rd_oor_answer", 64'(Scan_data_answer));
    chk("rd_oor_err", 64'(pat_rd_err));
    // No read strobe: outputs hold
    pat_rd_en = 1'b0; test_counter = 5'd3;
    expect_val(64'h1); expect_val(64'h0);
    tick();
    chk("rd_hold_err", 64'(pat_rd_err));
    chk("rd_hold_weight", 64'(Scan_data_weight));

    // Record row 2 = 0x14 with row flag
    detection_en = 1'b1; counter = 3'd2; single_pe_detection = 8'h14;
    row_fault_detection = 1'b1; column_fault_detection = 1'b0;
    expect_val(64'h14); expect_val(64'h04); expect_val(64'h00); expect_val(64'd0);
    tick();
    detection_en = 1'b0;
    chk("rec1_flat_row2", 64'(envm_faulty_patterns_flat[23:16]));
    chk("rec1_row_map", 64'(faulty_row_map));
    chk("rec1_col_map", 64'(faulty_column_map));
    chk("rec1_pe_count_lag", 64'(faulty_pe_count));
    expect_val(64'd2); expect_val(64'd1);
    tick();
    chk("rec1_pe_count", 64'(faulty_pe_count));
    chk("rec1_row_count", 64'(faulty_row_count));

    // Second record to row 2: sticky OR or overwrite
    detection_en = 1'b1; counter = 3'd2; single_pe_detection = 8'h01;
    row_fault_detection = 1'b1; column_fault_detection = 1'b1;
`ifdef ENVM_STICKY_ACCUM_EN
    expect_val(64'h15);
`else
    expect_val(64'h01);
`endif
    expect_val(64'h04);
    tick();
    detection_en = 1'b0;
    chk("rec2_flat_row2", 64'(envm_faulty_patterns_flat[23:16]));
    chk("rec2_col_map", 64'(faulty_column_map));
`ifdef ENVM_STICKY_ACCUM_EN
    expect_val(64'd3);
`else
    expect_val(64'd1);
`endif
    expect_val(64'd1);
    tick();
    chk("rec2_pe_count", 64'(faulty_pe_count));
    chk("rec2_col_count", 64'(faulty_col_count));

    // Clear wins over a same-cycle detection
    fault_clear = 1'b1; detection_en = 1'b1; counter = 3'd0; single_pe_detection = 8'hFF;
    row_fault_detection = 1'b1; column_fault_detection = 1'b1;
    expect_val(64'h0); expect_val(64'h0); expect_val(64'h0);
    tick();
    fault_clear = 1'b0; detection_en = 1'b0;
    chk("clr_flat", envm_faulty_patterns_flat);
    chk("clr_row_map", 64'(faulty_row_map));
    chk("clr_col_map", 64'(faulty_column_map));
    expect_val(64'd0); expect_val(64'd0); expect_val(64'd0);
    tick();
    chk("clr_pe_count", 64'(faulty_pe_count));
    chk("clr_row_count", 64'(faulty_row_count));
    chk("clr_col_count", 64'(faulty_col_count));

    // Populate every row with a distinct pattern
    row_fault_detection = 1'b0; column_fault_detection = 1'b0;
    for (int r = 0; r < Rows; r++) begin
      detection_en = 1'b1;
      counter = 3'(r);
      single_pe_detection = 8'(r * 37 + 5);
      exp_pe[r] = 8'(r * 37 + 5);
      tick();
    end
    detection_en = 1'b0;

    // Dump with dump_ready toggling; dump_start mid-dump must be ignored
    dump_start = 1'b1;
    for (int r = 0; r < Rows; r++) begin
      expect_val(64'(r));
      expect_val(64'(exp_pe[r]));
      expect_val(64'(r == Rows - 1));
    end
    tick();
    dump_start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 40 && beats < Rows; cyc++) begin
      dump_ready = (cyc % 2 == 0);
      dump_start = (cyc == 5);
      if (dump_valid && dump_ready) begin
        chk("dump_idx", 64'(dump_row_idx));
        chk("dump_data", 64'(dump_data));
        chk("dump_last", 64'(dump_last));
        beats++;
      end
      tick();
    end
    dump_ready = 1'b0; dump_start = 1'b0;
    expect_val(64'(Rows)); expect_val(64'h0); expect_val(64'h0);
    chk("dump_beats", 64'(beats));
    chk("dump_end_valid", 64'(dump_valid));
    chk("dump_end_busy", 64'(dump_busy));

    // Reset mid-dump at idx 4
    dump_start = 1'b1; dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick(); tick(); tick();
    expect_val(64'd4); expect_val(64'h1);
    chk("mid_dump_idx", 64'(dump_row_idx));
    chk("mid_dump_valid", 64'(dump_valid));
    rst_n = 1'b0;
    expect_val(64'h0); expect_val(64'h0); expect_val(64'h0); expect_val(64'h0);
    tick();
    rst_n = 1'b1;
    chk("rst_mid_valid", 64'(dump_valid));
    chk("rst_mid_busy", 64'(dump_busy));
    chk("rst_mid_idx", 64'(dump_row_idx));
    chk("rst_mid_flat", envm_faulty_patterns_flat);
    expect_val(64'h0);
    tick();
    chk("rst_mid_no_beat", 64'(dump_valid));

    // Pattern contents survive reset
    pat_rd_en = 1'b1; test_type = 1'b1; test_counter = 5'd17;
    expect_val(64'hFF); expect_val(64'h3FFFF); expect_val(64'h0);
    tick();
    pat_rd_en = 1'b0;
    chk("post_rst_weight", 64'(Scan_data_weight));
    chk("post_rst_answer", 64'(Scan_data_answer));
    chk("post_rst_pe_count", 64'(faulty_pe_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envm_fault_store.md
# envm_fault_store

Parametrised embedded-NVM model for the self-test/self-recovery path of a ROWS×COLS systolic array. It holds per-test-type scan patterns (weight, activation, expected answer) loaded through a write port and served with registered one-cycle reads. It records row, column and single-PE fault detections into a fault map with optional sticky accumulation across test passes. It exposes the flattened map and fault counts to the recovery logic, and streams the map row by row over a valid/ready dump port.

## Interface
- ROWS, 8, array rows
- COLS, 8, array columns
- WEIGHT_WIDTH, 8, weight bits
- ACTIVATION_WIDTH, 8, activation bits
- PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(ROWS), answer bits
- NUM_TEST_TYPES, 2, pattern banks (0 = SA, 1 = TD, further types allowed)
- PATTERN_DEPTH, 18, entries per bank
- TYPE_WIDTH, max(1,$clog2(NUM_TEST_TYPES)); PAT_ADDR_WIDTH, $clog2(PATTERN_DEPTH); IDX_WIDTH, max(1,$clog2(max(ROWS,COLS)))

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- pat_wr_en  in  1  pattern write strobe
- pat_wr_type, test_type  in  TYPE_WIDTH  write / read bank select
- pat_wr_addr, test_counter  in  PAT_ADDR_WIDTH  write / read entry
- pat_wr_weight / pat_wr_activation / pat_wr_answer  in  W / A / PSUM  write data
- pat_rd_en  in  1  read request
- Scan_data_weight / Scan_data_activation / Scan_data_answer  out  W / A / PSUM  read data
- pat_rd_err  out  1  last read was out of range
- detection_en  in  1  fault record strobe
- counter  in  IDX_WIDTH  row/column index being recorded
- single_pe_detection  in  COLS  per-PE faults of row `counter`
- row_fault_detection, column_fault_detection  in  1  whole-row / whole-column flags for index `counter`
- fault_clear  in  1  clear fault map
- envm_faulty_patterns_flat  out  ROWS*COLS  row i at [i*COLS +: COLS]
- faulty_row_map  out  ROWS; faulty_column_map  out  COLS
- faulty_pe_count  out  $clog2(ROWS*COLS+1); faulty_row_count  out  $clog2(ROWS+1); faulty_col_count  out  $clog2(COLS+1)
- dump_start  in  1; dump_ready  in  1
- dump_valid  out  1; dump_last  out  1; dump_busy  out  1
- dump_row_idx  out  IDX_WIDTH; dump_data  out  COLS

## Operation
- Pattern banks: NUM_TEST_TYPES×PATTERN_DEPTH entries, not reset (non-volatile contents).
- Write: on pat_wr_en with in-range type and address, the entry is written; out-of-range writes are dropped.
- Read: on pat_rd_en, the Scan_data_* registers load bank[test_type][test_counter] and pat_rd_err is cleared. If out of range, they load 0 and pat_rd_err is set. Without pat_rd_en, the outputs hold.
- Read/write to the same entry in the same cycle returns the old data.
- Fault record: on detection_en, the following update:
  - counter<ROWS: pe_map[counter] and row_map[counter] are updated.
  - counter<COLS: col_map[counter] is updated.
  - Out-of-range portions are ignored.
- fault_clear zeroes all maps and has priority over detection_en in the same cycle; that detection is lost.
- Counts: registered popcounts of pe_map, row_map and col_map.
- Dump FSM with states IDLE, SEND:
  - IDLE→SEND on dump_start: idx=0, dump_valid=1.
  - In SEND, a beat transfers on dump_valid&&dump_ready.
  - After each beat, idx increments. The beat at idx=ROWS-1 asserts dump_last, and its acceptance returns the FSM to IDLE with dump_valid=0.
  - dump_start while in SEND is ignored.
- dump_data = pe_map[dump_row_idx] live: a detection to the current row before acceptance is visible in that beat.
- dump_busy = (state==SEND).

## Timing
- Reset (rst_n=0 at an edge):
  - Scan_data_*=0, pat_rd_err=0.
  - All maps 0, all counts 0.
  - FSM to IDLE: dump_valid=0, dump_last=0, dump_row_idx=0, dump_busy=0.
  - Pattern contents unchanged.
  - Reset mid-dump aborts with no further beats.
- Pattern read latency: 1 cycle (pat_rd_en at edge N, data valid after edge N).
- Map update: visible on envm_faulty_patterns_flat and the maps after the edge of detection_en.
- Counts lag the maps by one cycle (2 cycles from detection_en).
- Dump: first beat is valid the cycle after dump_start. With dump_ready held at 1, ROWS beats follow in ROWS consecutive cycles. dump_valid, dump_row_idx and dump_data stay stable while dump_ready=0.

## Configuration
- ENVM_STICKY_ACCUM_EN defined: recording ORs into the stored bits (pe_map[r] |= single_pe_detection; row and column flags likewise). Faults persist across SA and TD passes until fault_clear or reset.
- ENVM_STICKY_ACCUM_EN undefined: recording overwrites (pe_map[r] = single_pe_detection, flags assigned directly).

## Test plan
- Write SA[3]={0x5A,0xC3,0x01234}, TD[17]={0xFF,0x80,0x3FFFF}; read type0/addr3, then type1/addr17 → values appear one cycle after each pat_rd_en. Read addr 18 → all zero, pat_rd_err=1.
- Record row 2 = 8'b0001_0100 with row flag 1 → flat[23:16]=0x14, row_map=0x04, faulty_pe_count=2 two cycles later.
- With sticky enabled, record row 2 = 0x01 after the previous step → flat[23:16]=0x15, count=3. With sticky disabled → 0x01, count=1.
- fault_clear and detection_en (row 0 = 0xFF) in the same cycle → all maps 0 and counts 0.
- dump_start with dump_ready toggling 1,0,1… → exactly 8 beats idx 0..7 in order, dump_last only on idx 7, data equals the map. dump_start during the dump is ignored.
- rst_n low mid-dump at idx 4 → dump_valid=0 and maps zero the next cycle. A prior pattern read after reset returns the pre-reset contents.
